// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module word_assembler
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             byte_vld,
  input  logic [7:0]       byte_in,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [31:0]      word
);

  logic [CNT_W-1:0] slot;
  logic [23:0]      low_q;

  // A flush in the same cycle as a byte makes that byte slot 0 of a fresh word.
  assign slot = flush ? '0 : byte_cnt;
  assign word = {byte_in, low_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
    end else if (byte_vld) begin
      byte_cnt <= slot + 1'b1;
    end else if (flush) begin
      byte_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld) begin
      case (slot)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads CELL_NUMBERS 32-bit words from a UART byte stream into instruction memory,
// holding the CPU in reset until done. Define LOADER_TIMEOUT_EN for the inter-byte timeout.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CELL_NUMBERS = 256,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELL_NUMBERS - 1);

  if (CELL_NUMBERS < 1 || CELL_NUMBERS > (2 ** ADDR_W)) begin : g_bad_cells
    $error("CELL_NUMBERS must lie in 1..2**ADDR_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [31:0]       word;
  logic              accept, flush, expire, word_done;

  // Reload beats a coincident byte; RUN ignores the stream entirely.
  assign accept    = rx_valid && !reload && (state_q != RUN);
  assign word_done = accept && !expire && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign flush     = reload || expire;

  word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .byte_vld (accept),
    .byte_in  (rx_data),
    .byte_cnt (byte_cnt),
    .word     (word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_q;
  logic            err_q;

  // Expiry is seen once TIMEOUT_CYC idle cycles have elapsed; a byte in that cycle starts a new word.
  assign expire = (state_q == LOAD) && (byte_cnt != '0) && (idle_q == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= expire && !reload;
      if (rx_valid || reload || expire || (state_q != LOAD) || (byte_cnt == '0)) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign timeout_err = err_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (word_done) state_d = WRITE;
      WRITE:   if (reload) state_d = LOAD;
               else if (idx_q == LAST_IDX) state_d = RUN;
               else state_d = LOAD;
      RUN:     if (reload) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (reload) begin
        idx_q <= '0;
      end else if (state_q == WRITE) begin
        idx_q <= idx_q + 1'b1;
      end
      if (word_done) begin
        imem_addr  <= idx_q;
        imem_wdata <= word;
      end
    end
  end

  assign imem_we   = (state_q == WRITE);
  assign cpu_rst   = (state_q != RUN);
  assign load_done = (state_q == RUN);

endmodule
